// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: two-entry skid buffer with registered in_ready,
// flush-to-bubble, and a saturating count of empty output cycles.
//
// state | meaning
// EMPTY | nothing held; out_data shows BUBBLE
// ONE   | main holds the payload presented downstream
// TWO   | main presented, skid holds the next payload; upstream stalled
module pipe_skid_stage #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Handshake outputs decode only the state flop, so no combinational
  // path runs from out_ready back to in_ready.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = (state_q != TWO);
    out_data  = main_q;
    occupancy = 2'd0;
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = TWO;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = EMPTY;
            main_d  = BUBBLE;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt <= '0;
    end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and streaming checks for pipe_skid_stage, plus a narrow-counter
// instance to observe bubble_cnt saturation.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [1:0]  occupancy;
  logic [15:0] bubble_cnt;

  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_occupancy;
  logic [3:0]  s_bubble_cnt;

  int tests = 0;
  int fails = 0;

  pipe_skid_stage #(.WIDTH(64), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_skid_stage #(.WIDTH(8), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(1'b0), .in_ready(s_in_ready), .in_data(8'h00),
    .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
    .occupancy(s_occupancy), .bubble_cnt(s_bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sent, recv, cycles;
    logic inf, outf, r0;

    // reset state and idle bubble counting
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_bubble", 64'(bubble_cnt), 64'd0);
    #10 reset = 1'b0;
    repeat (10) step();
    chk("bubble_10", 64'(bubble_cnt), 64'd10);
    repeat (10) step();
    chk("bubble_20", 64'(bubble_cnt), 64'd20);
    chk("bubble_sat", 64'(s_bubble_cnt), 64'd15);

    // single payload, latency 1
    reset = 1'b1;
    #2 reset = 1'b0;
    in_valid = 1'b1; in_data = 64'h0000_0004_0000_0013; out_ready = 1'b1;
    step();
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data", out_data, 64'h0000_0004_0000_0013);
    chk("t1_occupancy", 64'(occupancy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    step();
    chk("t1_drain", 64'(out_valid), 64'd0);

    // back-pressure: A, B fill the stage, C held off
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd1;
    step();
    in_data = 64'd2;
    step();
    chk("t2_occ2", 64'(occupancy), 64'd2);
    chk("t2_in_ready", 64'(in_ready), 64'd0);
    chk("t2_head_a", out_data, 64'd1);
    in_data = 64'd3;
    step();
    chk("t2_hold_occ", 64'(occupancy), 64'd2);
    chk("t2_hold_a", out_data, 64'd1);
    out_ready = 1'b1;
    step();
    chk("t2_b", out_data, 64'd2);
    chk("t2_b_occ", 64'(occupancy), 64'd1);
    step();
    chk("t2_c", out_data, 64'd3);
    chk("t2_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();
    chk("t2_empty", 64'(out_valid), 64'd0);
    chk("t2_empty_data", out_data, 64'd0);

    // flush while full, with an incoming payload
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd5;
    step();
    in_data = 64'd6;
    step();
    chk("t3_full", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = 64'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t3_occ", 64'(occupancy), 64'd0);
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_data", out_data, 64'd0);
    out_ready = 1'b1;
    step();
    chk("t3_stays_empty", 64'(out_valid), 64'd0);

    // flush while ONE with out_fire: stage empties
    in_valid = 1'b1; in_data = 64'd8;
    step();
    in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t3b_valid", 64'(out_valid), 64'd0);

    // async reset mid-cycle while full
    out_ready = 1'b0; in_valid = 1'b1; in_data = 64'd8;
    step();
    in_data = 64'd9;
    step();
    chk("t5_full", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_data", out_data, 64'd0);
    chk("t5_bubble", 64'(bubble_cnt), 64'd0);
    #1 reset = 1'b0;
    in_valid = 1'b1; in_data = 64'hAA; out_ready = 1'b1;
    step();
    chk("t5_post_data", out_data, 64'hAA);
    chk("t5_post_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    step();

    // random streaming of 1000 incrementing payloads
    sent = 0; recv = 0; cycles = 0;
    while (recv < 1000 && cycles < 20000) begin
      in_valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_data  = 64'(sent + 1);
      r0 = in_ready;
      out_ready = ~out_ready;
      #1;
      tests++;
      assert (in_ready === r0) else begin
        fails++;
        $error("FAIL comb_ready: observed %0b expected %0b", in_ready, r0);
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      inf  = in_valid & in_ready;
      outf = out_valid & out_ready;
      if (outf) begin
        recv++;
        chk("stream_data", out_data, 64'(recv));
      end
      step();
      if (inf) sent++;
      cycles++;
    end
    chk("stream_count", 64'(recv), 64'd1000);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
